// File: rtl/fifo_pkg.sv
// Shared constants, width helpers and status struct for fifo_sync_param.
package fifo_pkg;

    localparam int DATA_WIDTH_DEF = 8;

    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_status_t;

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port RAM for fifo_sync_param: synchronous write, registered synchronous read.
module fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic [AW-1:0]         waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [AW-1:0]         raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read-before-write on an address collision: a full FIFO doing read+write returns the old entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count and almost-full/empty thresholds.
// Define FIFO_ERR_FLAGS_EN to add sticky overflow/underflow flags with err_clr.
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = 16,
    parameter int AFULL_TH   = DEPTH - 2,
    parameter int AEMPTY_TH  = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [DATA_WIDTH-1:0]     data_in,
    input  logic                      rd_en,
    output logic [DATA_WIDTH-1:0]     data_out,
    output logic                      full,
    output logic                      empty,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic [cnt_w(DEPTH)-1:0]   count
`ifdef FIFO_ERR_FLAGS_EN
    ,
    input  logic                      err_clr,
    output logic                      overflow,
    output logic                      underflow
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fifo_sync_param: DEPTH must be a power of two >= 2");
    end
    if (!(AEMPTY_TH >= 1 && AEMPTY_TH < AFULL_TH && AFULL_TH <= DEPTH)) begin : g_bad_th
        $error("fifo_sync_param: need 1 <= AEMPTY_TH < AFULL_TH <= DEPTH");
    end

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q;
    logic          wr_acc, rd_acc;

    assign wr_acc   = wr_en && (!full || rd_en);
    assign rd_acc   = rd_en && !empty;
    assign wr_ptr_d = wr_ptr_q + PW'(wr_acc);
    assign rd_ptr_d = rd_ptr_q + PW'(rd_acc);

    // For a power-of-two depth the pointer difference spans 0..DEPTH exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= CW'(wr_ptr_d - rd_ptr_d);
        end
    end

    assign count        = count_q;
    assign full         = (count_q == CW'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CW'(AFULL_TH));
    assign almost_empty = (count_q <= CW'(AEMPTY_TH));

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i (data_in),
        .re_i    (rd_acc),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (data_out)
    );

`ifdef FIFO_ERR_FLAGS_EN
    logic ovf_q, unf_q;

    // A set event in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (wr_en && full && !rd_en) ovf_q <= 1'b1;
            else if (err_clr)            ovf_q <= 1'b0;
            if (rd_en && empty)          unf_q <= 1'b1;
            else if (err_clr)            unf_q <= 1'b0;
        end
    end

    assign overflow  = ovf_q;
    assign underflow = unf_q;
`endif

endmodule

// File: doc/fifo_sync_param.md
# fifo_sync_param

Parametrised single-clock FIFO, the successor to the fixed 8-bit FIFO driven through the existing FIFO interface. Adds configurable width and depth, an occupancy count, programmable almost-full and almost-empty thresholds, and optional sticky overflow/underflow error flags. It keeps the same `rd_en`/`wr_en`/`full`/`empty` semantics, so current drivers and monitors extend to it without protocol changes.

## Interface
- `DATA_WIDTH`, 8, data bus width in bits (≥1)
- `DEPTH`, 16, number of entries; power of two, ≥2
- `AFULL_TH`, DEPTH-2, `almost_full` asserts when count ≥ AFULL_TH
- `AEMPTY_TH`, 2, `almost_empty` asserts when count ≤ AEMPTY_TH
- `clk`  in  1  single clock, all state updates on posedge
- `rst`  in  1  reset, asynchronous, active-high
- `wr_en`  in  1  write request
- `data_in`  in  DATA_WIDTH  write data
- `rd_en`  in  1  read request
- `data_out`  out  DATA_WIDTH  read data, registered
- `full`  out  1  count == DEPTH
- `empty`  out  1  count == 0
- `almost_full`  out  1  count ≥ AFULL_TH
- `almost_empty`  out  1  count ≤ AEMPTY_TH
- `count`  out  $clog2(DEPTH+1)  current occupancy
- `overflow`  out  1  sticky write-while-full (FIFO_ERR_FLAGS_EN only)
- `underflow`  out  1  sticky read-while-empty (FIFO_ERR_FLAGS_EN only)
- `err_clr`  in  1  synchronous clear of sticky flags (FIFO_ERR_FLAGS_EN only)

## Operation
- Write pointer, read pointer: $clog2(DEPTH)+1 bits. The extra MSB distinguishes full from empty. Wrap-around is natural binary rollover.
- Accepted write = `wr_en && (!full || rd_en)`. Accepted read = `rd_en && !empty`.
- Full + rd_en + wr_en: both are accepted. Count stays DEPTH, `full` stays high.
- Empty + rd_en + wr_en: only the write is accepted. Count becomes 1, `data_out` holds its value.
- Rejected write: memory and pointers are unchanged. Rejected read: `data_out` holds.
- Count update per cycle: +1 on write only, −1 on read only, 0 on both or neither.
- All flags are decoded from the registered count, so they change in the cycle after the causing edge.
- Reset, even mid-operation, clears pointers and count immediately.
  - Reset values: `data_out`=0, `count`=0, `empty`=1, `full`=0, `almost_empty`=1, `almost_full`=0, `overflow`=0, `underflow`=0.
  - Memory contents are not reset.
- Threshold legality, checked by elaboration-time assertion: 1 ≤ AEMPTY_TH < AFULL_TH ≤ DEPTH.

## Timing
- Write latency: data accepted at edge N is readable by a `rd_en` sampled at edge N+1. `empty` deasserts after edge N.
- Read latency: 1 cycle. `rd_en` sampled at edge N puts data on `data_out` after edge N, valid through edge N+1 and held until the next accepted read.
- No combinational path from inputs to outputs.
- Sustained throughput: one write and one read per cycle.

## Configuration
- Macro: `FIFO_ERR_FLAGS_EN`.
- Defined:
  - `overflow` sets on any `wr_en` that is rejected because of full.
  - `underflow` sets on any `rd_en` while empty.
  - Both flags stay set until `err_clr` or `rst`.
  - If a set event and `err_clr` occur in the same cycle, the set wins.
- Undefined: the `overflow`, `underflow` and `err_clr` ports are absent, and no error logic is synthesised. Data path behaviour is identical in both builds.

## Structure
- Package `fifo_pkg` holds:
  - `DATA_WIDTH` default constant
  - `ptr_w(depth)` and `cnt_w(depth)` width functions
  - `fifo_status_t` packed struct of {full, empty, almost_full, almost_empty}, for bench monitors
- Sub-module `fifo_mem`: simple dual-port RAM, DEPTH×DATA_WIDTH, synchronous write and registered synchronous read. The top instantiates it and keeps pointers, count and flags.

## Test plan
DATA_WIDTH=8, DEPTH=8, AFULL_TH=6, AEMPTY_TH=2 throughout.
- Reset, then write 0x01..0x08 → `full`=1 and `count`=8 after the 8th edge; `almost_full` rises after the 6th write.
- From full, write 0xAA with rd_en=0 → write rejected, `count` stays 8; `overflow`=1 if enabled. Then read 8 times → data 0x01..0x08 in order.
- From empty, assert rd_en → `data_out` unchanged, `count`=0; `underflow`=1 if enabled. Pulse `err_clr` → flag clears the next cycle.
- From full, simultaneous rd_en+wr_en(0x55) for 20 cycles → `count` stays 8, reads return in FIFO order, pointers wrap twice, the 0x55 entries emerge last.
- From empty, simultaneous rd_en+wr_en(0x33) → `count`=1, `data_out` unchanged; next cycle rd_en → `data_out`=0x33, `empty`=1.
- After writing 5 entries, assert `rst` asynchronously mid-cycle → all outputs take their reset values immediately; write 0x77 then read → `data_out`=0x77.
